instr_sequencer: RTL and testbench



---
 rtl/instr_sequencer.sv | 142 ++++++++++++++
 tb/tb_instr_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: fetch/decode/execute with a handshaked
// data-memory phase, a bounded ack wait and sticky halt/error status.
module instr_sequencer #(
  parameter int PC_W    = 8,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  output logic [PC_W-1:0] imem_addr,
  input  logic [7:0]      imem_data,
  output logic [3:0]      opcode,
  output logic [1:0]      ra_sel,
  output logic [1:0]      rb_sel,
  input  logic            cu_reg_write,
  input  logic            cu_data_read,
  input  logic            cu_data_write,
  output logic            reg_we,
  output logic            mem_to_reg,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            mem_err,
  output logic            busy
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [7:0]        ir_q, ir_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              store_q, store_d;
  logic              halted_q, halted_d;
  logic              mem_err_q, mem_err_d;

  // State and datapath registers; reset wins over every transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= 8'h00;
      wait_q    <= '0;
      store_q   <= 1'b0;
      halted_q  <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      wait_q    <= wait_d;
      store_q   <= store_d;
      halted_q  <= halted_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Next-state logic and the same-cycle write-back strobe.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    wait_d     = wait_q;
    store_d    = store_q;
    halted_d   = halted_q;
    mem_err_d  = mem_err_q;
    reg_we     = 1'b0;
    mem_to_reg = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
        else     state_d = S_IDLE;
      end
      S_FETCH: begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        ir_d    = imem_data;
        pc_d    = pc_q + PC_W'(1);
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (opcode == 4'hF) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else if (cu_data_read || cu_data_write) begin
          state_d = S_MEM;
          wait_d  = '0;
          // A request flagged as both read and write is treated as a store.
          store_d = cu_data_write;
        end else begin
          reg_we  = cu_reg_write;
          state_d = run ? S_FETCH : S_IDLE;
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          reg_we     = ~store_q;
          mem_to_reg = ~store_q;
          state_d    = run ? S_FETCH : S_IDLE;
        end else if (wait_q == WAIT_LAST) begin
          wait_d    = wait_q + WAIT_W'(1);
          state_d   = S_HALT;
          halted_d  = 1'b1;
          mem_err_d = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign opcode    = ir_q[7:4];
  assign ra_sel    = ir_q[3:2];
  assign rb_sel    = ir_q[1:0];
  assign dmem_req  = (state_q == S_MEM);
  assign dmem_we   = (state_q == S_MEM) && store_q;
  assign halted    = halted_q;
  assign mem_err   = mem_err_q;
  assign busy      = (state_q != S_IDLE) && (state_q != S_HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: a behavioural imem/decoder drives the
// DUT; expected write-back strobes are queued and matched by a monitor.
module tb_instr_sequencer;

  logic       clk = 1'b0;
  logic       reset, run, dmem_ack;
  logic [7:0] imem_addr, imem_data, pc;
  logic [3:0] opcode;
  logic [1:0] ra_sel, rb_sel;
  logic       cu_reg_write, cu_data_read, cu_data_write;
  logic       reg_we, mem_to_reg, dmem_req, dmem_we, halted, mem_err, busy;

  typedef struct {
    int         cyc;
    logic       m2r;
    logic [1:0] ra;
    logic [1:0] rb;
  } wb_t;

  wb_t        sb[$];
  wb_t        mon_e;
  logic [7:0] imem [256];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  logic       mon_en = 1'b0;

  instr_sequencer #(.PC_W(8), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .run(run),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .opcode(opcode), .ra_sel(ra_sel), .rb_sel(rb_sel),
    .cu_reg_write(cu_reg_write), .cu_data_read(cu_data_read), .cu_data_write(cu_data_write),
    .reg_we(reg_we), .mem_to_reg(mem_to_reg),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .pc(pc), .halted(halted), .mem_err(mem_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous instruction memory: data valid one cycle after the address.
  always @(posedge clk) imem_data <= imem[imem_addr];

  // Decoder model: 3=ADD, 8=LOAD, 9=STORE, everything else no strobe.
  always_comb begin
    cu_reg_write  = (opcode == 4'h3) || (opcode == 4'h8);
    cu_data_read  = (opcode == 4'h8);
    cu_data_write = (opcode == 4'h9);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at cyc %0d", tag, got, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  always begin
    @(negedge clk);
    #2;
    if (mon_en) begin
      check_val("m2r_gated", {31'd0, mem_to_reg & ~reg_we}, 32'd0);
      if (reg_we) begin
        if (sb.size() == 0) begin
          check_val("spurious_we", {31'd0, reg_we}, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check_val("we_cycle", cyc, mon_e.cyc);
          check_val("we_m2r", {31'd0, mem_to_reg}, {31'd0, mon_e.m2r});
          check_val("we_ra", {30'd0, ra_sel}, {30'd0, mon_e.ra});
          check_val("we_rb", {30'd0, rb_sel}, {30'd0, mon_e.rb});
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push_wb(input int c, input logic m2r, input logic [1:0] ra, input logic [1:0] rb);
    wb_t e;
    e.cyc = c; e.m2r = m2r; e.ra = ra; e.rb = rb;
    sb.push_back(e);
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 8'h00;
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; dmem_ack = 1'b0;
    step();
    step();
    reset = 1'b0;
    clear_imem();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_imem();
    @(negedge clk);
    do_reset();
    mon_en = 1'b1;

    // Reset state and ADD r1,r2.
    check_val("rst_pc", pc, 8'h00);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_halted", halted, 1'b0);
    check_val("rst_mem_err", mem_err, 1'b0);
    check_val("rst_req", dmem_req, 1'b0);
    check_val("rst_we", dmem_we, 1'b0);
    check_val("rst_opcode", opcode, 4'h0);
    imem[0] = 8'h36;
    run = 1'b1;
    step();
    check_val("add_fetch_busy", busy, 1'b1);
    check_val("add_fetch_addr", imem_addr, 8'h00);
    push_wb(cyc + 2, 1'b0, 2'd1, 2'd2);
    step();
    check_val("add_dec_pc", pc, 8'h00);
    step();
    check_val("add_exec_pc", pc, 8'h01);
    check_val("add_exec_op", opcode, 4'h3);
    step();
    check_val("add_refetch_addr", imem_addr, 8'h01);
    check_val("add_refetch_busy", busy, 1'b1);

    // LOAD 0x81 acked in the third MEM cycle.
    do_reset();
    imem[0] = 8'h81;
    run = 1'b1;
    step(); step(); step(); step();
    for (int k = 0; k < 3; k++) begin
      check_val("ld_req", dmem_req, 1'b1);
      check_val("ld_we", dmem_we, 1'b0);
      if (k == 2) begin
        push_wb(cyc, 1'b1, 2'd0, 2'd1);
        dmem_ack = 1'b1;
      end
      step();
    end
    dmem_ack = 1'b0;
    check_val("ld_done_req", dmem_req, 1'b0);
    check_val("ld_done_busy", busy, 1'b1);
    check_val("ld_done_pc", pc, 8'h01);

    // STORE 0x94 never acked: timeout into HALT.
    do_reset();
    imem[0] = 8'h94;
    run = 1'b1;
    step(); step(); step(); step();
    for (int k = 0; k < 15; k++) begin
      check_val("st_req", dmem_req, 1'b1);
      check_val("st_we", dmem_we, 1'b1);
      step();
    end
    check_val("to_req", dmem_req, 1'b0);
    check_val("to_mem_err", mem_err, 1'b1);
    check_val("to_halted", halted, 1'b1);
    check_val("to_busy", busy, 1'b0);
    for (int k = 0; k < 4; k++) begin
      run = ~run;
      step();
      check_val("halt_hold", halted, 1'b1);
      check_val("halt_busy", busy, 1'b0);
      check_val("halt_pc", pc, 8'h01);
    end
    do_reset();
    check_val("rst_clr_halted", halted, 1'b0);
    check_val("rst_clr_mem_err", mem_err, 1'b0);

    // PC wrap over a NOP at 0xFF.
    run = 1'b1;
    for (int i = 0; i < 1000 && pc !== 8'hFF; i++) step();
    check_val("wrap_reach", pc, 8'hFF);
    step();
    check_val("wrap_fetch_addr", imem_addr, 8'hFF);
    step();
    step();
    check_val("wrap_pc", pc, 8'h00);

    // run dropped during a LOAD's MEM phase, then restart.
    do_reset();
    imem[0] = 8'h81;
    imem[1] = 8'h36;
    run = 1'b1;
    step(); step(); step(); step();
    check_val("rd_req", dmem_req, 1'b1);
    run = 1'b0;
    step();
    check_val("rd_req2", dmem_req, 1'b1);
    push_wb(cyc, 1'b1, 2'd0, 2'd1);
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    check_val("rd_idle_busy", busy, 1'b0);
    check_val("rd_idle_req", dmem_req, 1'b0);
    check_val("rd_idle_pc", pc, 8'h01);
    step();
    check_val("rd_idle_hold", busy, 1'b0);
    run = 1'b1;
    step();
    check_val("rd_restart_busy", busy, 1'b1);
    check_val("rd_restart_addr", imem_addr, 8'h01);
    push_wb(cyc + 2, 1'b0, 2'd1, 2'd2);
    step(); step();
    check_val("rd_add_pc", pc, 8'h02);
    step();

    // Reset during MEM; a late ack is ignored.
    do_reset();
    imem[0] = 8'h81;
    run = 1'b1;
    step(); step(); step(); step();
    check_val("rm_req", dmem_req, 1'b1);
    reset = 1'b1;
    step();
    check_val("rm_req_low", dmem_req, 1'b0);
    check_val("rm_pc", pc, 8'h00);
    check_val("rm_busy", busy, 1'b0);
    reset = 1'b0;
    run = 1'b0;
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    check_val("rm_late_busy", busy, 1'b0);
    check_val("rm_late_req", dmem_req, 1'b0);

    // Explicit HALT opcode.
    do_reset();
    imem[0] = 8'hF0;
    run = 1'b1;
    step(); step(); step(); step();
    check_val("hlt_halted", halted, 1'b1);
    check_val("hlt_mem_err", mem_err, 1'b0);
    check_val("hlt_busy", busy, 1'b0);
    step();
    check_val("hlt_stay_busy", busy, 1'b0);
    check_val("hlt_pc", pc, 8'h01);

    step();
    check_val("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
